// File: rtl/trap_pkg.sv
// Shared constants for the commit-stage trap controller: FSM encodings,
// exception codes, interrupt cause and privilege levels.
package trap_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [3:0] EXC_INST_MISALIGN  = 4'd0;
    localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ECALL_M        = 4'd11;

    localparam logic [31:0] IRQ_M_EXT_CAUSE = 32'h8000000B;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

    localparam int unsigned MSTATUS_MIE     = 3;
    localparam int unsigned MSTATUS_MPP_LO  = 11;
    localparam int unsigned MSTATUS_MPP_HI  = 12;

endpackage

// File: rtl/trap_ctrl.sv
// Commit-stage trap controller: classifies the WB instruction as retire, trap,
// MRET or external interrupt and drives CSR commit, flush and redirect.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit_valid,
    input  logic [DATA_WIDTH-1:0] commit_pc,
    input  logic                  exc_valid,
    input  logic [3:0]            exc_code,
    input  logic [DATA_WIDTH-1:0] exc_tval,
    input  logic                  is_mret,
    input  logic                  irq_ext,
    input  logic                  mem_stall,
    input  logic [DATA_WIDTH-1:0] mstatus_in,
    input  logic [DATA_WIDTH-1:0] handler_addr,
    input  logic [DATA_WIDTH-1:0] mret_addr,
    output logic                  inst_commit,
    output logic                  exception_commit,
    output logic                  mret_commit,
    output logic [DATA_WIDTH-1:0] exception_pc,
    output logic [DATA_WIDTH-1:0] exception_cause,
    output logic [DATA_WIDTH-1:0] exception_tval,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [1:0]            priv_level
);

    logic [1:0]            state_q, state_d;
    logic                  inst_commit_d, exception_commit_d, mret_commit_d;
    logic                  flush_d, redirect_valid_d;
    logic [DATA_WIDTH-1:0] exception_pc_d, exception_cause_d, exception_tval_d;
    logic [DATA_WIDTH-1:0] redirect_pc_d;
    logic [1:0]            priv_level_d;
    logic                  take_trap_c;
    logic                  mstatus_unused_c;

    // Only MIE and MPP are consumed from mstatus.
    assign mstatus_unused_c = ^mstatus_in;

    // Next-state and next-output selection; event priority lives in IDLE.
    always_comb begin
        state_d            = state_q;
        inst_commit_d      = 1'b0;
        exception_commit_d = 1'b0;
        mret_commit_d      = 1'b0;
        flush_d            = 1'b0;
        redirect_valid_d   = 1'b0;
        exception_pc_d     = exception_pc;
        exception_cause_d  = exception_cause;
        exception_tval_d   = exception_tval;
        redirect_pc_d      = redirect_pc;
        priv_level_d       = priv_level;
        take_trap_c        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (commit_valid && !mem_stall) begin
                    if (exc_valid) begin
                        take_trap_c       = 1'b1;
                        exception_cause_d = DATA_WIDTH'(exc_code);
                        exception_tval_d  = exc_tval;
                    end else if (is_mret) begin
                        state_d          = ST_ISSUE;
                        mret_commit_d    = 1'b1;
                        inst_commit_d    = 1'b1;
                        flush_d          = 1'b1;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = mret_addr;
                    end else if (irq_ext && mstatus_in[MSTATUS_MIE]) begin
                        take_trap_c       = 1'b1;
                        exception_cause_d = DATA_WIDTH'(IRQ_M_EXT_CAUSE);
                        exception_tval_d  = '0;
                    end else begin
                        inst_commit_d = 1'b1;
                    end
                end
                if (take_trap_c) begin
                    state_d            = ST_ISSUE;
                    exception_commit_d = 1'b1;
                    flush_d            = 1'b1;
                    redirect_valid_d   = 1'b1;
                    redirect_pc_d      = handler_addr;
                    exception_pc_d     = commit_pc;
                end
            end
            ST_ISSUE: begin
                state_d = ST_DRAIN;
                flush_d = 1'b1;
                // mret_commit is high exactly while an MRET sits in ISSUE.
                priv_level_d = mret_commit ? mstatus_in[MSTATUS_MPP_HI:MSTATUS_MPP_LO] : PRIV_M;
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            inst_commit      <= 1'b0;
            exception_commit <= 1'b0;
            mret_commit      <= 1'b0;
            flush            <= 1'b0;
            redirect_valid   <= 1'b0;
            exception_pc     <= '0;
            exception_cause  <= '0;
            exception_tval   <= '0;
            redirect_pc      <= '0;
            priv_level       <= PRIV_M;
        end else begin
            state_q          <= state_d;
            inst_commit      <= inst_commit_d;
            exception_commit <= exception_commit_d;
            mret_commit      <= mret_commit_d;
            flush            <= flush_d;
            redirect_valid   <= redirect_valid_d;
            exception_pc     <= exception_pc_d;
            exception_cause  <= exception_cause_d;
            exception_tval   <= exception_tval_d;
            redirect_pc      <= redirect_pc_d;
            priv_level       <= priv_level_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl: retire, trap, MRET, interrupt
// gating, stall hold-off and reset during drain.
module tb_trap_ctrl;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          commit_valid;
    logic [DW-1:0] commit_pc;
    logic          exc_valid;
    logic [3:0]    exc_code;
    logic [DW-1:0] exc_tval;
    logic          is_mret;
    logic          irq_ext;
    logic          mem_stall;
    logic [DW-1:0] mstatus_in;
    logic [DW-1:0] handler_addr;
    logic [DW-1:0] mret_addr;
    logic          inst_commit;
    logic          exception_commit;
    logic          mret_commit;
    logic [DW-1:0] exception_pc;
    logic [DW-1:0] exception_cause;
    logic [DW-1:0] exception_tval;
    logic          flush;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;
    logic [1:0]    priv_level;

    int total = 0;
    int bad   = 0;

    trap_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .commit_valid     (commit_valid),
        .commit_pc        (commit_pc),
        .exc_valid        (exc_valid),
        .exc_code         (exc_code),
        .exc_tval         (exc_tval),
        .is_mret          (is_mret),
        .irq_ext          (irq_ext),
        .mem_stall        (mem_stall),
        .mstatus_in       (mstatus_in),
        .handler_addr     (handler_addr),
        .mret_addr        (mret_addr),
        .inst_commit      (inst_commit),
        .exception_commit (exception_commit),
        .mret_commit      (mret_commit),
        .exception_pc     (exception_pc),
        .exception_cause  (exception_cause),
        .exception_tval   (exception_tval),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .priv_level       (priv_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        commit_valid = 1'b0;
        exc_valid    = 1'b0;
        is_mret      = 1'b0;
        irq_ext      = 1'b0;
        mem_stall    = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        idle_inputs();
        commit_pc    = '0;
        exc_code     = '0;
        exc_tval     = '0;
        mstatus_in   = '0;
        handler_addr = 32'h80;
        mret_addr    = 32'h204;

        step();
        step();
        check("rst_priv", 32'(priv_level), 32'h3);
        check("rst_flush", 32'(flush), 0);
        check("rst_icommit", 32'(inst_commit), 0);
        check("rst_ecommit", 32'(exception_commit), 0);
        check("rst_rpc", redirect_pc, 0);
        check("rst_cause", exception_cause, 0);
        rst = 1'b0;

        // Three back-to-back normal commits.
        for (int i = 0; i < 3; i++) begin
            commit_valid = 1'b1;
            commit_pc    = 32'h100 + 32'(4 * i);
            step();
            check("ret_icommit", 32'(inst_commit), 1);
            check("ret_flush", 32'(flush), 0);
        end
        idle_inputs();
        step();
        check("ret_idle", 32'(inst_commit), 0);

        // Illegal instruction trap.
        commit_valid = 1'b1;
        exc_valid    = 1'b1;
        exc_code     = 4'd2;
        exc_tval     = 32'hDEAD0013;
        commit_pc    = 32'h200;
        step();
        check("ill_ecommit", 32'(exception_commit), 1);
        check("ill_cause", exception_cause, 32'h2);
        check("ill_pc", exception_pc, 32'h200);
        check("ill_tval", exception_tval, 32'hDEAD0013);
        check("ill_rpc", redirect_pc, 32'h80);
        check("ill_rvalid", 32'(redirect_valid), 1);
        check("ill_flush1", 32'(flush), 1);
        check("ill_icommit", 32'(inst_commit), 0);
        exc_valid = 1'b0;
        commit_pc = 32'h204;
        step();
        check("ill_flush2", 32'(flush), 1);
        check("ill_rvalid2", 32'(redirect_valid), 0);
        check("ill_ecommit2", 32'(exception_commit), 0);
        check("ill_hold_cause", exception_cause, 32'h2);
        step();
        check("drain_ignores_commit", 32'(inst_commit), 0);
        check("ill_flush3", 32'(flush), 0);
        step();
        check("idle_resamples", 32'(inst_commit), 1);
        idle_inputs();

        // MRET back to user mode.
        mstatus_in   = 32'h0;
        commit_valid = 1'b1;
        is_mret      = 1'b1;
        step();
        check("mret_mcommit", 32'(mret_commit), 1);
        check("mret_icommit", 32'(inst_commit), 1);
        check("mret_ecommit", 32'(exception_commit), 0);
        check("mret_rpc", redirect_pc, 32'h204);
        check("mret_priv_issue", 32'(priv_level), 32'h3);
        idle_inputs();
        step();
        check("mret_priv_drain", 32'(priv_level), 32'h0);
        check("mret_flush2", 32'(flush), 1);
        step();

        // Masked interrupt: both commits retire.
        irq_ext = 1'b1;
        for (int i = 0; i < 2; i++) begin
            commit_valid = 1'b1;
            commit_pc    = 32'h2F8 + 32'(4 * i);
            step();
            check("irqm_icommit", 32'(inst_commit), 1);
            check("irqm_ecommit", 32'(exception_commit), 0);
        end
        mstatus_in = 32'h8;
        commit_pc  = 32'h300;
        exc_tval   = 32'h5555AAAA;
        step();
        check("irq_ecommit", 32'(exception_commit), 1);
        check("irq_cause", exception_cause, 32'h8000000B);
        check("irq_pc", exception_pc, 32'h300);
        check("irq_tval", exception_tval, 0);
        check("irq_icommit", 32'(inst_commit), 0);
        idle_inputs();
        mstatus_in = 32'h0;
        step();
        check("irq_priv", 32'(priv_level), 32'h3);
        step();

        // Exception held off by mem_stall.
        commit_valid = 1'b1;
        exc_valid    = 1'b1;
        exc_code     = 4'd4;
        exc_tval     = 32'h1234;
        commit_pc    = 32'h400;
        mem_stall    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_ecommit", 32'(exception_commit), 0);
            check("stall_flush", 32'(flush), 0);
        end
        mem_stall = 1'b0;
        step();
        check("unstall_ecommit", 32'(exception_commit), 1);
        check("unstall_cause", exception_cause, 32'h4);
        idle_inputs();
        step();
        step();

        // exc_valid and is_mret together, then reset in DRAIN.
        commit_valid = 1'b1;
        exc_valid    = 1'b1;
        is_mret      = 1'b1;
        exc_code     = 4'd3;
        commit_pc    = 32'h500;
        step();
        check("both_ecommit", 32'(exception_commit), 1);
        check("both_mcommit", 32'(mret_commit), 0);
        check("both_icommit", 32'(inst_commit), 0);
        check("both_cause", exception_cause, 32'h3);
        idle_inputs();
        step();
        check("both_drain_flush", 32'(flush), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_flush", 32'(flush), 0);
        check("mid_rst_priv", 32'(priv_level), 32'h3);
        check("mid_rst_cause", exception_cause, 0);
        #2 rst = 1'b0;
        step();
        check("post_rst_flush", 32'(flush), 0);
        commit_valid = 1'b1;
        step();
        check("post_rst_retire", 32'(inst_commit), 1);
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Commit-stage trap controller that sits directly upstream of the machine-mode CSR register file. It watches the instruction leaving writeback and decides whether that instruction retires normally, raises a synchronous exception, executes MRET, or is pre-empted by a machine external interrupt. It then drives the CSR file's commit/cause/pc/tval inputs and the pipeline's flush and redirect. It also holds the current privilege level.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, tval, cause, mstatus and CSR addresses.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- commit_valid  in  1  WB stage holds a valid instruction.
- commit_pc  in  DATA_WIDTH  PC of the WB instruction.
- exc_valid  in  1  WB instruction carries a synchronous exception.
- exc_code  in  4  exception code (trap_pkg constants).
- exc_tval  in  DATA_WIDTH  faulting address or instruction.
- is_mret  in  1  WB instruction is MRET.
- irq_ext  in  1  level-sensitive machine external interrupt request.
- mem_stall  in  1  memory/cache stall; WB is frozen.
- mstatus_in  in  DATA_WIDTH  current mstatus from the CSR file (bit 3 = MIE, bits 12:11 = MPP).
- handler_addr  in  DATA_WIDTH  mtvec from the CSR file.
- mret_addr  in  DATA_WIDTH  mepc from the CSR file.
- inst_commit  out  1  retire pulse, goes to minstret.
- exception_commit  out  1  trap-entry pulse.
- mret_commit  out  1  MRET pulse.
- exception_pc, exception_cause, exception_tval  out  DATA_WIDTH  trap payload, valid while exception_commit is high.
- flush  out  1  kill all instructions in IF through WB.
- redirect_valid  out  1  load PC from redirect_pc.
- redirect_pc  out  DATA_WIDTH  new fetch PC.
- priv_level  out  2  current privilege level.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- Sampling in IDLE: an event is sampled only when commit_valid=1 and mem_stall=0. While mem_stall=1 nothing is sampled and all outputs are 0.
- Priority, highest first:
  1. exc_valid: trap. cause={28'b0,exc_code}; pc=commit_pc; tval=exc_tval.
  2. is_mret: return.
  3. irq_ext && mstatus_in[3]: interrupt. cause=32'h8000000B; pc=commit_pc; tval=0. The WB instruction is not retired.
  4. Otherwise: normal retire.
- Normal retire: inst_commit pulses for 1 cycle on the following edge. The FSM stays in IDLE.
- Trap, MRET or interrupt: the payload is latched and the FSM moves to ISSUE.
- ISSUE (1 cycle):
  - For a trap or interrupt: exception_commit=1, redirect_pc=handler_addr, priv_level←2'b11.
  - For MRET: mret_commit=1, inst_commit=1, redirect_pc=mret_addr, priv_level←mstatus_in[12:11] as sampled in ISSUE.
  - flush=1, redirect_valid=1.
  - Next state is DRAIN.
- DRAIN (1 cycle): flush=1, redirect_valid=0, commit_valid is ignored. Next state is IDLE.
- Trapping instructions never pulse inst_commit. MRET retires.
- Interrupt while mstatus_in[3]=0: ignored. irq_ext stays pending (level) and is taken at the first eligible commit.

## Timing
- Reset values:
  - State = IDLE.
  - All 1-bit outputs = 0.
  - exception_pc, exception_cause, exception_tval, redirect_pc = 0.
  - priv_level = 2'b11.
- All outputs are registered; none depends combinationally on an input.
- Latency:
  - Normal retire: sample edge to inst_commit = 1 cycle.
  - Trap: sample edge to exception_commit, flush and redirect = 1 cycle.
  - Trap: flush stays high for 2 cycles total.
- Back-to-back traps: minimum spacing is 3 cycles (IDLE→ISSUE→DRAIN→IDLE).
- mem_stall in ISSUE or DRAIN: ignored. The FSM advances unconditionally, and the pipeline honours flush over stall.
- Reset mid-ISSUE or mid-DRAIN: state returns to IDLE immediately and the pending redirect is dropped.
- exc_valid and is_mret both high: treated as an exception; mret_commit is not asserted.
- exception_* hold their last value outside ISSUE.

## Structure
- trap_pkg holds:
  - the state enum (IDLE/ISSUE/DRAIN);
  - exception codes EXC_INST_MISALIGN=0, EXC_ILLEGAL=2, EXC_BREAKPOINT=3, EXC_LOAD_MISALIGN=4, EXC_STORE_MISALIGN=6, EXC_ECALL_M=11;
  - IRQ_M_EXT_CAUSE=32'h8000000B;
  - PRIV_M=2'b11, PRIV_U=2'b00.
- Single module, no sub-module. Priority selection is an always_comb block inside trap_ctrl.

## Test plan
- Reset, then 3 normal commits at PC 0x100, 0x104, 0x108: 3 inst_commit pulses, each 1 cycle after its sample edge; no flush.
- Illegal instruction at PC 0x200, exc_code=2, tval=0xDEAD0013, mtvec=0x80: 1 cycle later exception_commit=1, cause=2, pc=0x200, tval=0xDEAD0013, redirect_pc=0x80; flush high for 2 cycles; inst_commit=0.
- MRET with mepc=0x204 and MPP=00: mret_commit=1, inst_commit=1, redirect_pc=0x204; priv_level goes 11→00 after ISSUE.
- irq_ext=1 with MIE=0 across 2 commits: both retire. Then set MIE=1 at commit PC 0x300: cause=0x8000000B, pc=0x300, tval=0, no inst_commit.
- Exception held with mem_stall=1 for 4 cycles: no outputs during the stall. exception_commit fires 1 cycle after mem_stall falls.
- exc_valid and is_mret together, followed by rst asserted during DRAIN: exception taken, no mret_commit. After reset: IDLE, flush=0, priv_level=11.
